branch_predictor: RTL and testbench

//  Fetch-side direction/target predictor that pairs with the execute-stage branch resolution logic.
//  - Fetch: looks up if_pc and returns a predicted direction and target.
//  - Execute: receives the resolved outcome (taken, target) and trains a direct-mapped table.

---
 rtl/branch_predictor_pkg.sv | 27 ++
 rtl/branch_predictor_if.sv | 36 +++
 rtl/branch_predictor_sat_ctr.sv | 20 ++
 rtl/branch_predictor.sv | 90 +++++++++
 tb/tb_branch_predictor.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/branch_predictor_pkg.sv
// Shared types and helpers for the fetch-side branch predictor.
//   bp_ctr_t   : 2-bit saturating direction counter (SNT/WNT/WT/ST)
//   bp_entry_t : one direct-mapped table entry (valid, tag, target, counter)
//   bp_idx/bp_tag : PC -> table index / stored tag (pc[1:0] ignored)
package bp_pkg;
  localparam int BP_XLEN  = 32;
  localparam int BP_IDX_W = 6;
  localparam int BP_TAG_W = 8;
  localparam logic [BP_XLEN-1:0] BP_PC_INC = 32'd4;

  typedef enum logic [1:0] {SNT = 2'b00, WNT = 2'b01, WT = 2'b10, ST = 2'b11} bp_ctr_t;

  typedef struct packed {
    logic                valid;
    logic [BP_TAG_W-1:0] tag;
    logic [BP_XLEN-1:0]  tgt;
    bp_ctr_t             ctr;
  } bp_entry_t;

  function automatic logic [BP_IDX_W-1:0] bp_idx(input logic [BP_XLEN-1:0] pc);
    return pc[BP_IDX_W+1:2];
  endfunction

  function automatic logic [BP_TAG_W-1:0] bp_tag(input logic [BP_XLEN-1:0] pc);
    return pc[BP_IDX_W+BP_TAG_W+1:BP_IDX_W+2];
  endfunction
endpackage

// File: rtl/branch_predictor_if.sv
// Fetch lookup / execute resolution bundle for branch_predictor.
//   master : pipeline side (drives IF/EX requests, consumes prediction/redirect)
//   slave  : predictor side
interface branch_predictor_if;
  import bp_pkg::*;
  // fetch lookup
  logic               if_valid;
  logic [BP_XLEN-1:0] if_pc;
  logic               pred_taken;
  logic [BP_XLEN-1:0] pred_target;
  // execute resolution
  logic               ex_valid;
  logic [BP_XLEN-1:0] ex_pc;
  logic               ex_is_branch;
  logic               ex_is_jal;
  logic               ex_taken;
  logic [BP_XLEN-1:0] ex_target;
  logic               ex_pred_taken;
  logic [BP_XLEN-1:0] ex_pred_target;
  // redirect and statistics
  logic               redirect;
  logic [BP_XLEN-1:0] redirect_pc;
  logic [31:0]        br_cnt;
  logic [31:0]        mispred_cnt;

  modport master (
    output if_valid, if_pc, ex_valid, ex_pc, ex_is_branch, ex_is_jal,
           ex_taken, ex_target, ex_pred_taken, ex_pred_target,
    input  pred_taken, pred_target, redirect, redirect_pc, br_cnt, mispred_cnt
  );
  modport slave (
    input  if_valid, if_pc, ex_valid, ex_pc, ex_is_branch, ex_is_jal,
           ex_taken, ex_target, ex_pred_taken, ex_pred_target,
    output pred_taken, pred_target, redirect, redirect_pc, br_cnt, mispred_cnt
  );
endinterface

// File: rtl/branch_predictor_sat_ctr.sv
// bp_sat_ctr: next-state function of the 2-bit direction counter.
//   i_ctr      : current counter
//   i_taken    : resolved direction (taken increments, not-taken decrements)
//   i_force_st : unconditional jump, counter goes straight to ST
//   o_ctr      : next counter, saturating at SNT/ST
module bp_sat_ctr
  import bp_pkg::*;
(
  input  bp_ctr_t i_ctr,
  input  logic    i_taken,
  input  logic    i_force_st,
  output bp_ctr_t o_ctr
);
  always_comb begin
    o_ctr = i_ctr;
    if (i_force_st)           o_ctr = ST;
    else if (i_taken)  begin if (i_ctr != ST)  o_ctr = bp_ctr_t'(i_ctr + 2'd1); end
    else               begin if (i_ctr != SNT) o_ctr = bp_ctr_t'(i_ctr - 2'd1); end
  end
endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped direction + target predictor (64 entries).
//   clk, reset_n : core clock, async active-low reset
//   bp (slave)   : fetch lookup (if_*/pred_*), execute training (ex_*),
//                  mispredict redirect (redirect/redirect_pc), statistics counters
// Lookup is purely combinational from table flops; training lands on the clock
// edge, so a same-cycle lookup of the trained index sees the old contents.
module branch_predictor
  import bp_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  branch_predictor_if.slave bp
);
  localparam int ENTRIES = 1 << BP_IDX_W;

  bp_entry_t r_tbl [ENTRIES];
  logic [31:0] r_br_cnt, r_mispred_cnt;

  // ---------------- fetch lookup ----------------
  logic [BP_IDX_W-1:0] w_if_idx;
  bp_entry_t           w_if_ent;
  logic [1:0]          w_if_ctr;
  logic                w_if_hit;

  assign w_if_idx = bp_idx(bp.if_pc);
  assign w_if_ent = r_tbl[w_if_idx];
  assign w_if_ctr = w_if_ent.ctr;
  assign w_if_hit = w_if_ent.valid & (w_if_ent.tag == bp_tag(bp.if_pc));

  assign bp.pred_taken  = bp.if_valid & w_if_hit & w_if_ctr[1];
  assign bp.pred_target = bp.pred_taken ? w_if_ent.tgt : bp.if_pc + BP_PC_INC;

  // ---------------- execute resolution ----------------
  logic [BP_IDX_W-1:0] w_ex_idx;
  bp_entry_t           w_ex_ent;
  logic                w_ex_hit, w_ctrl, w_ctrl_v, w_mispred, w_redirect;
  bp_ctr_t             w_ctr_nxt;

  assign w_ex_idx = bp_idx(bp.ex_pc);
  assign w_ex_ent = r_tbl[w_ex_idx];
  assign w_ex_hit = w_ex_ent.valid & (w_ex_ent.tag == bp_tag(bp.ex_pc));
  assign w_ctrl   = bp.ex_is_branch | bp.ex_is_jal;
  assign w_ctrl_v = bp.ex_valid & w_ctrl;

  // A non-control instruction predicted taken means fetch hit an aliased
  // entry; it must be redirected to the fall-through PC.
  assign w_mispred = bp.ex_valid &
                     ((w_ctrl & (bp.ex_taken != bp.ex_pred_taken)) |
                      (w_ctrl & bp.ex_taken & (bp.ex_pred_target != bp.ex_target)) |
                      (~w_ctrl & bp.ex_pred_taken));
  assign w_redirect     = reset_n & w_mispred;
  assign bp.redirect    = w_redirect;
  // Without a redirect the value is held at the fall-through PC.
  assign bp.redirect_pc = (w_redirect & w_ctrl & bp.ex_taken) ? bp.ex_target
                                                              : bp.ex_pc + BP_PC_INC;

  bp_sat_ctr u_sat_ctr (
    .i_ctr      (w_ex_ent.ctr),
    .i_taken    (bp.ex_taken),
    .i_force_st (bp.ex_is_jal),
    .o_ctr      (w_ctr_nxt)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < ENTRIES; i++)
        r_tbl[i] <= '{valid: 1'b0, tag: '0, tgt: '0, ctr: WNT};
      r_br_cnt      <= '0;
      r_mispred_cnt <= '0;
    end else begin
      if (w_ctrl_v) begin
        r_br_cnt <= r_br_cnt + 32'd1;
        if (w_ex_hit) begin
          r_tbl[w_ex_idx].ctr <= w_ctr_nxt;
          if (bp.ex_taken) r_tbl[w_ex_idx].tgt <= bp.ex_target;
        end else if (bp.ex_taken) begin
          // cold allocate: JAL is always taken, so start it fully saturated
          r_tbl[w_ex_idx] <= '{valid: 1'b1, tag: bp_tag(bp.ex_pc), tgt: bp.ex_target,
                               ctr: (bp.ex_is_jal ? ST : WT)};
        end
      end else if (bp.ex_valid & bp.ex_pred_taken) begin
        r_tbl[w_ex_idx].valid <= 1'b0;
      end
      if (w_redirect) r_mispred_cnt <= r_mispred_cnt + 32'd1;
    end
  end

  assign bp.br_cnt      = r_br_cnt;
  assign bp.mispred_cnt = r_mispred_cnt;
endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboarded random + directed bench for branch_predictor.
module tb_branch_predictor;
  logic clk, reset_n;
  branch_predictor_if bus();

  branch_predictor dut (.clk(clk), .reset_n(reset_n), .bp(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit rst_n, ifv; bit [31:0] ifpc;
    bit exv, br, jal, tk; bit [31:0] pc, tgt;
    bit ptk; bit [31:0] ptgt;
  } stim_t;

  typedef struct {
    bit ptk; bit [31:0] ptgt; bit rd; bit [31:0] rpc, br, mis;
  } exp_t;

  exp_t q[$];
  int n_vec = 0, n_err = 0;

  // Reference model: plain per-index arrays, counter kept as an integer 0..3.
  bit          m_valid [64];
  bit [31:0]   m_tag   [64];
  bit [31:0]   m_tgt   [64];
  int          m_ctr   [64];
  int unsigned m_br, m_mis;

  function automatic int idx_of(input bit [31:0] pc); return int'((pc >> 2) % 64); endfunction
  function automatic bit [31:0] tag_of(input bit [31:0] pc); return (pc >> 8) % 256; endfunction

  function automatic void m_reset();
    for (int i = 0; i < 64; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 1;
    end
    m_br = 0; m_mis = 0;
  endfunction

  function automatic void m_lookup(input bit v, input bit [31:0] pc,
                                   output bit tk, output bit [31:0] t);
    int i = idx_of(pc);
    bit hit = m_valid[i] && (m_tag[i] == tag_of(pc));
    tk = v && hit && (m_ctr[i] >= 2);
    t  = tk ? m_tgt[i] : pc + 4;
  endfunction

  function automatic stim_t mk(bit ifv, bit [31:0] ifpc, bit exv, bit br, bit jal, bit tk,
                               bit [31:0] pc, bit [31:0] tgt, bit ptk, bit [31:0] ptgt);
    stim_t s;
    s.rst_n = 1; s.ifv = ifv; s.ifpc = ifpc; s.exv = exv; s.br = br; s.jal = jal;
    s.tk = tk; s.pc = pc; s.tgt = tgt; s.ptk = ptk; s.ptgt = ptgt;
    return s;
  endfunction

  function automatic stim_t look(bit [31:0] pc);
    return mk(1, pc, 0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0);
  endfunction

  // Drive one cycle, push the expected response, then advance the model past
  // the coming clock edge.
  task automatic step(input stim_t s);
    exp_t e;
    bit ctrl, hit; int i;
    @(posedge clk); #1;
    reset_n = s.rst_n;
    bus.if_valid = s.ifv; bus.if_pc = s.ifpc;
    bus.ex_valid = s.exv; bus.ex_pc = s.pc; bus.ex_is_branch = s.br; bus.ex_is_jal = s.jal;
    bus.ex_taken = s.tk; bus.ex_target = s.tgt;
    bus.ex_pred_taken = s.ptk; bus.ex_pred_target = s.ptgt;
    if (!s.rst_n) m_reset();
    m_lookup(s.ifv, s.ifpc, e.ptk, e.ptgt);
    ctrl = s.br || s.jal;
    e.rd = s.rst_n && s.exv &&
           (ctrl ? ((s.tk != s.ptk) || (s.tk && s.ptgt != s.tgt)) : s.ptk);
    e.rpc = (e.rd && ctrl && s.tk) ? s.tgt : s.pc + 4;
    e.br = m_br; e.mis = m_mis;
    q.push_back(e);
    if (s.rst_n) begin
      i = idx_of(s.pc);
      hit = m_valid[i] && (m_tag[i] == tag_of(s.pc));
      if (s.exv && ctrl) begin
        m_br++;
        if (hit) begin
          if (s.jal)      m_ctr[i] = 3;
          else if (s.tk)  m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
          else            m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
          if (s.tk) m_tgt[i] = s.tgt;
        end else if (s.tk) begin
          m_valid[i] = 1; m_tag[i] = tag_of(s.pc); m_tgt[i] = s.tgt;
          m_ctr[i] = s.jal ? 3 : 2;
        end
      end else if (s.exv && s.ptk) begin
        m_valid[i] = 0;
      end
      if (e.rd) m_mis++;
    end
  endtask

  function automatic void chk(string name, bit [31:0] act, bit [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Monitor: the DUT presents a response every cycle the driver issues one.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("pred_taken",  32'(bus.pred_taken), 32'(e.ptk));
        chk("pred_target", bus.pred_target,     e.ptgt);
        chk("redirect",    32'(bus.redirect),   32'(e.rd));
        chk("redirect_pc", bus.redirect_pc,     e.rpc);
        chk("br_cnt",      bus.br_cnt,          e.br);
        chk("mispred_cnt", bus.mispred_cnt,     e.mis);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  function automatic bit [31:0] rnd_pc();
    return (32'($urandom_range(0, 1)) << 8) | (32'($urandom_range(0, 7)) << 2) |
           32'($urandom_range(0, 3));
  endfunction

  function automatic bit [31:0] rnd_tgt();
    bit [31:0] pool [4];
    pool[0] = 32'h80; pool[1] = 32'h200; pool[2] = 32'h240; pool[3] = 32'h1000;
    return pool[$urandom_range(0, 3)];
  endfunction

  initial begin
    stim_t s;
    bit ptk; bit [31:0] ptgt;
    int kind;
    reset_n = 1'b0;
    bus.if_valid = 0; bus.if_pc = 0; bus.ex_valid = 0; bus.ex_pc = 0;
    bus.ex_is_branch = 0; bus.ex_is_jal = 0; bus.ex_taken = 0; bus.ex_target = 0;
    bus.ex_pred_taken = 0; bus.ex_pred_target = 0;
    m_reset();

    // 1: reset then cold lookup
    s = look(32'h100); s.rst_n = 0; step(s); step(s);
    step(look(32'h100));
    // 2: cold taken beq -> allocate + redirect
    step(mk(0, 0, 1, 1, 0, 1, 32'h100, 32'h80, 0, 32'h104));
    step(look(32'h100));
    // 3: train taken x3 then not-taken x3
    for (int k = 0; k < 6; k++) begin
      m_lookup(1, 32'h100, ptk, ptgt);
      step(mk(1, 32'h100, 1, 1, 0, (k < 3), 32'h100, 32'h80, ptk, ptgt));
    end
    step(look(32'h100));
    // 4: aliasing non-branch invalidates entry (re-train first so it hits)
    step(mk(0, 0, 1, 1, 0, 1, 32'h100, 32'h80, 0, 32'h104));
    step(mk(0, 0, 1, 1, 0, 1, 32'h100, 32'h80, 1, 32'h80));
    step(mk(1, 32'h100, 1, 0, 0, 0, 32'h100 + (32'h1 << 16), 32'h0, 1, 32'h80));
    step(look(32'h100));
    // 5: same-cycle update/lookup of idx 0x10, then reset mid-stream
    step(mk(0, 0, 1, 1, 0, 1, 32'h40, 32'h200, 0, 32'h44));
    step(mk(1, 32'h40, 1, 1, 0, 0, 32'h40, 32'h200, 1, 32'h200));
    step(mk(1, 32'h40, 1, 1, 0, 0, 32'h40, 32'h200, 0, 32'h44));
    step(look(32'h40));
    s = mk(1, 32'h40, 1, 1, 0, 1, 32'h40, 32'h200, 0, 32'h44); s.rst_n = 0; step(s);
    step(look(32'h40));
    // 6: JAL with stale target
    step(mk(0, 0, 1, 0, 1, 1, 32'h300, 32'h200, 0, 32'h304));
    step(mk(1, 32'h300, 1, 0, 1, 1, 32'h300, 32'h240, 1, 32'h200));
    step(look(32'h300));

    // random traffic
    for (int n = 0; n < 2000; n++) begin
      s.rst_n = ($urandom_range(0, 199) != 0);
      s.ifv  = ($urandom_range(0, 3) != 0);
      s.ifpc = rnd_pc();
      s.exv  = ($urandom_range(0, 9) != 0);
      s.pc   = rnd_pc();
      kind   = int'($urandom_range(0, 9));
      s.br   = (kind <= 5);
      s.jal  = (kind == 6 || kind == 7);
      s.tk   = s.jal ? 1'b1 : 1'($urandom_range(0, 1));
      s.tgt  = rnd_tgt();
      m_lookup(1, s.pc, ptk, ptgt);
      if ($urandom_range(0, 4) != 0 || !(s.br || s.jal)) begin
        s.ptk = ptk; s.ptgt = ptgt;
      end else begin
        s.ptk = 1'($urandom_range(0, 1)); s.ptgt = rnd_tgt();
      end
      step(s);
    end

    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      n_vec++; n_err++;
      $display("FAIL drain: %0d responses left, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
